// File: rtl/mult_share_arb.sv
// Shares one signed WIDTH x WIDTH multiplier between two requesters via round-robin arbitration.
// Latency: request handshake in cycle T, response valid from cycle T+2; one request in flight at a time.
// Backpressure: the response is held until the owner's rsp ready; no request is accepted outside IDLE.
module mult_share_arb #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*WIDTH-1:0]   rsp_z,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic                 owner;
    logic                 last_grant;
    logic [2*WIDTH-1:0]   z_reg;
    logic                 rsp0_valid_reg;
    logic                 rsp1_valid_reg;
    logic                 busy_reg;

    logic                 grant0;
    logic                 grant1;
    logic                 owner_ready;
    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   b_ext;
    logic [2*WIDTH-1:0]   product;

    // Round-robin grant: a lone requester always wins; under contention the
    // requester that was not served last wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;

    // Sign-extending both operands to full product width makes the low
    // 2*WIDTH bits of an unsigned multiply equal the signed product.
    assign a_ext   = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
    assign b_ext   = {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
    assign product = a_ext * b_ext;

    assign owner_ready = owner ? rsp1_ready : rsp0_ready;

    // Arbitration/multiply FSM; z_reg doubles as the rsp_z output register and
    // is only non-zero while a response is being presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            z_reg          <= '0;
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        a_reg    <= req0_a;
                        b_reg    <= req0_b;
                        owner    <= 1'b0;
                        busy_reg <= 1'b1;
                        state    <= MUL;
                    end else if (req1_ready) begin
                        a_reg    <= req1_a;
                        b_reg    <= req1_b;
                        owner    <= 1'b1;
                        busy_reg <= 1'b1;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    z_reg          <= product;
                    rsp0_valid_reg <= !owner;
                    rsp1_valid_reg <= owner;
                    state          <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        last_grant     <= owner;
                        z_reg          <= '0;
                        rsp0_valid_reg <= 1'b0;
                        rsp1_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    z_reg          <= '0;
                    rsp0_valid_reg <= 1'b0;
                    rsp1_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

    assign rsp_z      = z_reg;
    assign rsp0_valid = rsp0_valid_reg;
    assign rsp1_valid = rsp1_valid_reg;
    assign busy       = busy_reg;

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Time-shares one 8x8 signed (two's-complement) multiplier between two requesters.
- Each requester has its own valid/ready request channel and valid/ready response channel.
- A round-robin arbiter grants one request at a time. A 3-state FSM registers the operands, registers the product and holds the result until it is consumed.
- Sits between operand producers and the shared multiplier datapath; replaces a per-requester multiplier pair.

Parameters:
- WIDTH, 8, operand width in bits; product width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req0_a  input  WIDTH  requester 0 multiplicand, signed.
- req0_b  input  WIDTH  requester 0 multiplier, signed.
- req1_valid  input  1  requester 1 has operands.
- req1_ready  output  1  requester 1 operands accepted this cycle.
- req1_a  input  WIDTH  requester 1 multiplicand, signed.
- req1_b  input  WIDTH  requester 1 multiplier, signed.
- rsp0_valid  output  1  product for requester 0 available.
- rsp0_ready  input  1  requester 0 consumes product.
- rsp1_valid  output  1  product for requester 1 available.
- rsp1_ready  input  1  requester 1 consumes product.
- rsp_z  output  2*WIDTH  signed product; shared bus, qualified by rsp0_valid/rsp1_valid.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - On rst=1 at a clock edge: FSM goes to IDLE.
  - Operand, owner and product registers clear to 0.
  - Priority pointer last_grant is set to 1, so requester 0 wins the first contention.
  - All outputs are 0 during and after reset until the next request.
- States: IDLE, MUL, RESP.
- IDLE:
  - Grant rule:
    - Only req0_valid high: grant 0.
    - Only req1_valid high: grant 1.
    - Both high: grant the requester != last_grant.
  - reqN_ready is combinational and asserted only for the granted N, only in IDLE. Ready may depend on valid.
  - On a handshake (valid&ready): capture a, b and owner=N. Next state MUL.
  - Neither valid: stay in IDLE.
- MUL:
  - Product = signed(a_reg) * signed(b_reg), full 2*WIDTH precision, no truncation or saturation.
  - Product registered into z_reg. Next state RESP unconditionally.
- RESP:
  - rsp_z = z_reg. rsp<owner>_valid=1; the other rspN_valid=0.
  - rsp_z and rspN_valid stay stable while rsp<owner>_ready=0.
  - On rsp<owner>_ready=1: last_grant <= owner, next state IDLE.
  - rsp ready of the non-owner is ignored.
- Latency and throughput:
  - Request handshake in cycle T -> rsp valid from cycle T+2.
  - Minimum spacing between accepted requests is 3 cycles. No new request is accepted outside IDLE.
- rsp_z outside RESP is 0.
- Fairness: with both requesters continuously valid and responses consumed immediately, grants strictly alternate 0,1,0,1...
- Reset mid-operation (MUL or RESP): the transaction is dropped and no response is issued. The requester must re-issue.
- Arithmetic corners (WIDTH=8):
  - -128*-128 = +16384 (0x4000).
  - -128*127 = -16256 (0xC080).
  - 0*x = 0.

Test Plan:
- Single request: after reset, req0 a=3, b=-5 (0xFB) valid in cycle T -> req0_ready=1 in T; rsp0_valid=1 from T+2 with rsp_z=0xFFF1; rsp1_valid=0 throughout; busy high T+1..RESP exit.
- Simultaneous contention after reset: req0 (a=2, b=7) and req1 (a=-4, b=6) both valid -> req0 granted first with rsp_z=0x000E; req1 granted on the next IDLE with rsp_z=0xFFE8.
- Continuous contention: both valid for 4 transactions, rsp ready tied high -> grant order 0,1,0,1; a handshake every 3 cycles.
- Backpressure: rsp1_ready held low 5 cycles in RESP (owner=1) -> rsp1_valid and rsp_z held constant; req0_ready stays 0 though req0_valid=1; req0 is granted in the cycle after rsp1_ready rises.
- Corner operands: -128*-128 -> 0x4000; -128*127 -> 0xC080; 127*127 -> 0x3F01; 0*-1 -> 0x0000.
- Reset mid-op: assert rst for 1 cycle while in MUL -> next cycle IDLE, busy=0, no rspN_valid ever asserted for the dropped request; following contention grants req0 first.
